// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, the pointer breaks ties.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt[0] = valid[0] & (~valid[1] | ~ptr);
        gnt[1] = valid[1] & (~valid[0] | ptr);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// with registered operands and results so the ALU path is isolated.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy
);

    localparam logic PtrReset = 1'(PRIO_RESET);

    state_e           state_q, state_d;
    logic             ptr_q;
    logic             gnt_id_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       ctrl_q;
    logic             zero_q;

    logic [1:0]       gnt;
    logic             idle;
    logic             accept;
    logic             rsp_ready_g;

    rr_arb2 u_rr_arb2 (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr_q),
        .gnt   (gnt)
    );

    assign idle        = (state_q == StIdle);
    assign accept      = idle & (|gnt);
    assign rsp_ready_g = gnt_id_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready_g) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= PtrReset;
            gnt_id_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_id_q <= gnt[1];
                // Hand priority to whichever requester was not just served.
                ptr_q    <= ~gnt[1];
                a_q      <= gnt[1] ? req1_a    : req0_a;
                b_q      <= gnt[1] ? req1_b    : req0_b;
                ctrl_q   <= gnt[1] ? req1_ctrl : req0_ctrl;
            end
            if (state_q == StExec) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    // Ready is gated by reset so nothing is acknowledged while reset is held.
    assign req0_ready  = gnt[0] & idle & ~reset;
    assign req1_ready  = gnt[1] & idle & ~reset;

    assign rsp0_valid  = (state_q == StResp) & ~gnt_id_q;
    assign rsp1_valid  = (state_q == StResp) &  gnt_id_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

    assign alu_srca    = a_q;
    assign alu_srcb    = b_q;
    assign alu_control = ctrl_q;

    assign busy        = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [31:0] req0_a, req0_b, rsp0_result;
    logic [2:0]  req0_ctrl;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] req1_a, req1_b, rsp1_result;
    logic [2:0]  req1_ctrl;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .PRIO_RESET(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    // Reference ALU; unknown codes give 0 with zero set.
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            ALU_ADD: alu_result = alu_srca + alu_srcb;
            ALU_SUB: alu_result = alu_srca - alu_srcb;
            ALU_AND: alu_result = alu_srca & alu_srcb;
            ALU_OR:  alu_result = alu_srca | alu_srcb;
            ALU_SLT: alu_result = (alu_srca < alu_srcb) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete uncontended transaction on requester id.
    task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [31:0] er, input logic ez,
                         input string tag);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
        end
        #1;
        chk({tag, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        chk({tag, "_other_ready"}, {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_busy_exec"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_rsp_valid"}, {31'd0, id ? rsp1_valid : rsp0_valid}, 32'd1);
        chk({tag, "_other_rsp_valid"}, {31'd0, id ? rsp0_valid : rsp1_valid}, 32'd0);
        chk({tag, "_result"}, id ? rsp1_result : rsp0_result, er);
        chk({tag, "_zero"}, {31'd0, id ? rsp1_zero : rsp0_zero}, {31'd0, ez});
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk({tag, "_rsp_done"}, {31'd0, id ? rsp1_valid : rsp0_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; rsp1_ready = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_result", rsp0_result, 32'd0);
        chk("rst_srca", alu_srca, 32'd0);
        chk("rst_control", {29'd0, alu_control}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        do_op(1'b0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, "add5_7");

        // Restore pointer to 0 before the contention case.
        reset = 1'b1;
        #1;
        reset = 1'b0;

        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = ALU_SUB;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = ALU_OR;
        #1;
        chk("cont_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("cont_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("cont_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("cont_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("cont_sub_result", rsp0_result, 32'd0);
        chk("cont_sub_zero", {31'd0, rsp0_zero}, 32'd1);
        chk("cont_resp_req1_ready", {31'd0, req1_ready}, 32'd0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("cont_req1_ready_after", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("cont_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("cont_or_result", rsp1_result, 32'hFF);
        chk("cont_or_zero", {31'd0, rsp1_zero}, 32'd0);

        // Back-pressure on requester 1 while requester 0 waits.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = ALU_ADD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("bp_result", rsp1_result, 32'hFF);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
        end
        req1_valid = 1'b1; req1_a = 32'hC; req1_b = 32'hA; req1_ctrl = ALU_AND;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("bp_ptr0_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("bp_ptr0_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("bp_rsp0_result", rsp0_result, 32'd3);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_rsp1_and", rsp1_result, 32'd8);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        do_op(1'b0, 32'd3, 32'd5, ALU_SLT, 32'd1, 1'b0, "slt3_5");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd0, 1'b1, "slt_unsigned");
        do_op(1'b1, 32'd1, 32'd1, 3'b111, 32'd0, 1'b1, "undef111");

        // Asynchronous reset while in EXEC.
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_ctrl = ALU_ADD;
        #1;
        chk("mid_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("mid_busy_exec", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("mid_rst_srca", alu_srca, 32'd0);
        reset = 1'b0;
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
            chk("mid_no_rsp1", {31'd0, rsp1_valid}, 32'd0);
        end
        do_op(1'b1, 32'hC, 32'hA, ALU_AND, 32'd8, 1'b0, "post_rst_and");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
